// File: rtl/wb_stage_reg_if.sv
// rtl/wb_stage_reg_if.sv - MEM/WB stage bus: pipeline inputs, writeback and counter outputs
interface wb_stage_reg_if #(
   parameter int CNT_WIDTH = 32
);
   logic                 stall;
   logic                 flush;
   logic                 inst_ex_valid;
   logic [31:0]          inst_ex;
   logic [31:0]          pc_ex;
   logic [31:0]          alu_ex;
   logic [31:0]          dmem_dout;
   logic                 cnt_clr;
   logic [31:0]          inst_mem;
   logic                 valid_wb;
   logic [31:0]          wb_data;
   logic                 rf_we;
   logic [4:0]           rf_wa;
   logic [CNT_WIDTH-1:0] cycle_cnt;
   logic [CNT_WIDTH-1:0] instret_cnt;

   modport slave (
      input  stall, flush, inst_ex_valid, inst_ex, pc_ex, alu_ex, dmem_dout, cnt_clr,
      output inst_mem, valid_wb, wb_data, rf_we, rf_wa, cycle_cnt, instret_cnt
   );

   modport master (
      output stall, flush, inst_ex_valid, inst_ex, pc_ex, alu_ex, dmem_dout, cnt_clr,
      input  inst_mem, valid_wb, wb_data, rf_we, rf_wa, cycle_cnt, instret_cnt
   );
endinterface

// File: rtl/wb_stage_reg.sv
// rtl/wb_stage_reg.sv - MEM/WB pipeline register, load formatting, writeback select, perf counters
module wb_stage_reg #(
   parameter logic [31:0] NOP_INST  = 32'h0000_0013,
   parameter int          CNT_WIDTH = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   wb_stage_reg_if.slave   bus
);
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [31:0]          r_inst;
   logic                 r_valid;
   logic [31:0]          r_pc;
   logic [31:0]          r_alu;
   logic [CNT_WIDTH-1:0] r_cycle;
   logic [CNT_WIDTH-1:0] r_instret;

   logic [6:0]           w_opcode;
   logic [2:0]           w_funct3;
   logic [1:0]           w_off;
   logic [4:0]           w_rd;
   logic [7:0]           w_byte;
   logic [15:0]          w_half;
   logic [31:0]          w_load;
   logic [31:0]          w_wb;
   logic                 w_we;
   logic                 w_retire;

   assign w_opcode = r_inst[6:0];
   assign w_funct3 = r_inst[14:12];
   assign w_rd     = r_inst[11:7];
   assign w_off    = r_alu[1:0];
   // Only a real, unstalled, unflushed capture counts as a retired instruction
   assign w_retire = !bus.flush && !bus.stall && bus.inst_ex_valid;

   // MEM/WB register: flush inserts a bubble, stall holds, otherwise capture ID/EX
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inst  <= NOP_INST;
         r_valid <= 1'b0;
         r_pc    <= 32'h0;
         r_alu   <= 32'h0;
      end else if (bus.flush) begin
         r_inst  <= NOP_INST;
         r_valid <= 1'b0;
      end else if (!bus.stall) begin
         r_inst  <= bus.inst_ex;
         r_valid <= bus.inst_ex_valid;
         r_pc    <= bus.pc_ex;
         r_alu   <= bus.alu_ex;
      end
   end

   // Cycle and instret counters; clear beats a same-edge increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycle   <= '0;
         r_instret <= '0;
      end else if (bus.cnt_clr) begin
         r_cycle   <= '0;
         r_instret <= '0;
      end else begin
         r_cycle <= r_cycle + CNT_ONE;
         if (w_retire) begin
            r_instret <= r_instret + CNT_ONE;
         end
      end
   end

   // Load data alignment and extension; halfword uses off[1] only
   always_comb begin
      w_byte = 8'h00;
      w_load = bus.dmem_dout;
      case (w_off)
         2'd0:    w_byte = bus.dmem_dout[7:0];
         2'd1:    w_byte = bus.dmem_dout[15:8];
         2'd2:    w_byte = bus.dmem_dout[23:16];
         default: w_byte = bus.dmem_dout[31:24];
      endcase
      w_half = w_off[1] ? bus.dmem_dout[31:16] : bus.dmem_dout[15:0];
      case (w_funct3)
         3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_load = {24'h0, w_byte};
         3'b001:  w_load = {{16{w_half[15]}}, w_half};
         3'b101:  w_load = {16'h0, w_half};
         default: w_load = bus.dmem_dout;
      endcase
   end

   // Writeback value select and RegFile write enable
   always_comb begin
      w_wb = r_alu;
      case (w_opcode)
         OP_LOAD:         w_wb = w_load;
         OP_JAL, OP_JALR: w_wb = r_pc + 32'd4;
         default:         w_wb = r_alu;
      endcase
      w_we = r_valid && (w_rd != 5'd0) &&
             (w_opcode != OP_STORE) && (w_opcode != OP_BRANCH) && (w_opcode != OP_SYSTEM);
   end

   assign bus.inst_mem    = r_inst;
   assign bus.valid_wb    = r_valid;
   assign bus.wb_data     = w_wb;
   assign bus.rf_we       = w_we;
   assign bus.rf_wa       = w_rd;
   assign bus.cycle_cnt   = r_cycle;
   assign bus.instret_cnt = r_instret;
endmodule

// File: tb/tb_wb_stage_reg.sv
// tb/tb_wb_stage_reg.sv - self-checking bench for wb_stage_reg
module tb_wb_stage_reg;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   wb_stage_reg_if #(.CNT_WIDTH(32)) bus ();

   wb_stage_reg #(.NOP_INST(32'h0000_0013), .CNT_WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        stall, flush, valid, clr;
      logic [31:0] inst, pc, alu, dout;
      logic [31:0] e_inst;
      logic        e_valid;
      logic        chk_wb;
      logic [31:0] e_wb;
      logic        e_we;
      logic [4:0]  e_wa;
      logic [31:0] e_cycle, e_instret;
   } vec_t;

   vec_t vecs[$];

   // reference model state
   logic [31:0] m_inst, m_pc, m_alu, m_cycle, m_instret;
   logic        m_valid, m_known;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] sext(input int unsigned v, input int bits);
      int unsigned lim = 1 << bits;
      if (v >= (lim >> 1)) return 32'(v) - 32'(lim);
      return 32'(v);
   endfunction

   function automatic logic [31:0] exp_wb(input logic [31:0] inst, input logic [31:0] pc,
                                          input logic [31:0] alu, input logic [31:0] dout);
      int unsigned off = alu % 4;
      int unsigned b = (dout >> (8 * off)) % 256;
      int unsigned h = (dout >> (16 * (off / 2))) % 65536;
      case (inst[6:0])
         7'h03: case (inst[14:12])
                   3'd0: return sext(b, 8);
                   3'd4: return 32'(b);
                   3'd1: return sext(h, 16);
                   3'd5: return 32'(h);
                   default: return dout;
                endcase
         7'h6F, 7'h67: return pc + 32'd4;
         default: return alu;
      endcase
   endfunction

   function automatic logic exp_we(input logic v, input logic [31:0] inst);
      return v && (inst[11:7] != 0) && !(inst[6:0] inside {7'h23, 7'h63, 7'h73});
   endfunction

   task automatic drive(input logic st, input logic fl, input logic v, input logic [31:0] inst,
                        input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] dout,
                        input logic clr);
      bus.stall = st; bus.flush = fl; bus.inst_ex_valid = v; bus.inst_ex = inst;
      bus.pc_ex = pc; bus.alu_ex = alu; bus.dmem_dout = dout; bus.cnt_clr = clr;
   endtask

   function automatic logic [31:0] rnd_inst();
      logic [6:0] ops [9] = '{7'h03, 7'h13, 7'h33, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h73, 7'h37};
      logic [31:0] r = $urandom;
      r[6:0] = ops[$urandom_range(0, 8)];
      return r;
   endfunction

   initial begin
      drive(0, 0, 0, 32'h13, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_inst", bus.inst_mem, 32'h13);
      chk("rst_valid", 32'(bus.valid_wb), 0);
      chk("rst_wb", bus.wb_data, 0);
      chk("rst_we", 32'(bus.rf_we), 0);
      chk("rst_cycle", bus.cycle_cnt, 0);
      chk("rst_instret", bus.instret_cnt, 0);
      rst_n = 1'b1;

      //           st fl v  clr inst          pc            alu       dout           e_inst        ev cw e_wb          we wa cyc ir
      vecs = '{
         '{0,0,0,0, 32'h13,       0,            0,        0,            32'h13,       0, 1, 0,            0, 0, 1, 0},
         '{0,0,0,0, 32'h13,       0,            0,        0,            32'h13,       0, 1, 0,            0, 0, 2, 0},
         '{0,0,0,0, 32'h13,       0,            0,        0,            32'h13,       0, 1, 0,            0, 0, 3, 0},
         '{0,0,1,0, 32'h00700293, 32'h100,      7,        0,            32'h00700293, 1, 1, 7,            1, 5, 4, 1},
         '{0,0,1,0, 32'h00000303, 32'h104,      32'h1003, 32'h80FF0102, 32'h00000303, 1, 1, 32'hFFFFFF80, 1, 6, 5, 2},
         '{0,0,1,0, 32'h00005383, 32'h108,      32'h1002, 32'h80FF0102, 32'h00005383, 1, 1, 32'h000080FF, 1, 7, 6, 3},
         '{0,0,1,0, 32'h000000EF, 32'hFFFFFFFC, 32'h55,   0,            32'h000000EF, 1, 1, 0,            1, 1, 7, 4},
         '{0,0,1,0, 32'h00700293, 32'h10C,      7,        0,            32'h00700293, 1, 1, 7,            1, 5, 8, 5},
         '{1,0,1,0, 32'h00A00313, 32'h110,      10,       0,            32'h00700293, 1, 1, 7,            1, 5, 9, 5},
         '{1,0,1,0, 32'h00A00313, 32'h110,      10,       0,            32'h00700293, 1, 1, 7,            1, 5, 10, 5},
         '{1,1,1,0, 32'h00A00313, 32'h110,      10,       0,            32'h13,       0, 0, 0,            0, 0, 11, 5},
         '{0,0,1,1, 32'h00700293, 32'h114,      7,        0,            32'h00700293, 1, 1, 7,            1, 5, 0, 0},
         '{0,0,1,0, 32'h00502023, 32'h118,      32'h20,   0,            32'h00502023, 1, 1, 32'h20,       0, 0, 1, 1},
         '{0,0,1,0, 32'h00001403, 32'h11C,      32'h1001, 32'h80FF0102, 32'h00001403, 1, 1, 32'h00000102, 1, 8, 2, 2},
         '{0,0,0,0, 32'h00700293, 32'h120,      7,        0,            32'h00700293, 0, 1, 7,            0, 5, 3, 2}
      };

      foreach (vecs[i]) begin
         drive(vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].inst,
               vecs[i].pc, vecs[i].alu, vecs[i].dout, vecs[i].clr);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_inst", i), bus.inst_mem, vecs[i].e_inst);
         chk($sformatf("v%0d_valid", i), 32'(bus.valid_wb), 32'(vecs[i].e_valid));
         if (vecs[i].chk_wb) chk($sformatf("v%0d_wb", i), bus.wb_data, vecs[i].e_wb);
         chk($sformatf("v%0d_we", i), 32'(bus.rf_we), 32'(vecs[i].e_we));
         chk($sformatf("v%0d_wa", i), 32'(bus.rf_wa), 32'(vecs[i].e_wa));
         chk($sformatf("v%0d_cycle", i), bus.cycle_cnt, vecs[i].e_cycle);
         chk($sformatf("v%0d_instret", i), bus.instret_cnt, vecs[i].e_instret);
      end

      // randomized run against the model, seeded from the last table row's state
      m_inst = 32'h00700293; m_valid = 0; m_pc = 32'h120; m_alu = 7;
      m_cycle = 3; m_instret = 2; m_known = 1;
      for (int n = 0; n < 400; n++) begin
         logic st, fl, v, clr;
         logic [31:0] inst, pc, alu, dout;
         st = ($urandom_range(0, 3) == 0);
         fl = ($urandom_range(0, 7) == 0);
         v = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 31) == 0);
         inst = rnd_inst(); pc = $urandom; alu = $urandom; dout = $urandom;
         drive(st, fl, v, inst, pc, alu, dout, clr);
         if (clr) begin
            m_cycle = 0; m_instret = 0;
         end else begin
            m_cycle++;
            if (v && !st && !fl) m_instret++;
         end
         if (fl) begin
            m_inst = 32'h13; m_valid = 0; m_known = 0;
         end else if (!st) begin
            m_inst = inst; m_valid = v; m_pc = pc; m_alu = alu; m_known = 1;
         end
         @(posedge clk);
         #1;
         bus.dmem_dout = $urandom;
         #1;
         chk("r_inst", bus.inst_mem, m_inst);
         chk("r_valid", 32'(bus.valid_wb), 32'(m_valid));
         if (m_known) chk("r_wb", bus.wb_data, exp_wb(m_inst, m_pc, m_alu, bus.dmem_dout));
         chk("r_we", 32'(bus.rf_we), 32'(exp_we(m_valid, m_inst)));
         chk("r_wa", 32'(bus.rf_wa), 32'(m_inst[11:7]));
         chk("r_cycle", bus.cycle_cnt, m_cycle);
         chk("r_instret", bus.instret_cnt, m_instret);
      end

      // asynchronous reset asserted mid-stall, away from any clock edge
      drive(1, 0, 1, 32'h00700293, 0, 7, 0, 0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_inst", bus.inst_mem, 32'h13);
      chk("arst_valid", 32'(bus.valid_wb), 0);
      chk("arst_wb", bus.wb_data, 0);
      chk("arst_we", 32'(bus.rf_we), 0);
      chk("arst_cycle", bus.cycle_cnt, 0);
      chk("arst_instret", bus.instret_cnt, 0);
      // reset held across flush+stall edges still dominates
      drive(1, 1, 1, 32'h00700293, 0, 7, 0, 0);
      @(posedge clk);
      #1;
      chk("arst_hold_cycle", bus.cycle_cnt, 0);
      rst_n = 1'b1;
      drive(0, 0, 1, 32'h00700293, 0, 7, 0, 0);
      @(posedge clk);
      #1;
      chk("post_rst_cycle", bus.cycle_cnt, 1);
      chk("post_rst_instret", bus.instret_cnt, 1);
      chk("post_rst_wb", bus.wb_data, 7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/wb_stage_reg.md
Name: wb_stage_reg

Overview:
Final pipeline register plus writeback stage of the 3-stage RV32I core. Captures the instruction leaving ID/EX into the MEM/WB register and presents it to the ID/EX forwarding control as inst_mem. Formats load data from the synchronous-read DMEM and selects the writeback value; this value feeds both the RegFile write port and the forwarding path. Also owns the cycle and instret performance counters.

Parameters:
NOP_INST, 32'h0000_0013, instruction loaded on reset/flush (addi x0,x0,0)
CNT_WIDTH, 32, width of cycle/instret counters

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold MEM/WB register contents this edge
flush  in  1  replace captured instruction with bubble this edge
inst_ex_valid  in  1  inst_ex is a real instruction (not bubble)
inst_ex  in  32  instruction leaving ID/EX
pc_ex  in  32  PC of inst_ex
alu_ex  in  32  ALU result / DMEM byte address of inst_ex
dmem_dout  in  32  DMEM read word, valid in the cycle after address presented
cnt_clr  in  1  synchronous clear of both counters
inst_mem  out  32  registered instruction in WB (to forwarding control)
valid_wb  out  1  registered valid bit
wb_data  out  32  writeback value (RegFile wd and forward data)
rf_we  out  1  RegFile write enable
rf_wa  out  5  RegFile write address (inst_mem[11:7])
cycle_cnt  out  CNT_WIDTH  cycles since reset/clear
instret_cnt  out  CNT_WIDTH  retired instructions since reset/clear

Behaviour:
- Reset (rst_n low, async): inst_mem=NOP_INST, valid_wb=0, internal pc/alu regs=0, counters=0; hence rf_we=0, wb_data=0 (ALU path of 0). Release takes effect on the next rising edge.
- Register update priority per edge: flush > stall > load.
  - flush: inst_mem<=NOP_INST, valid_wb<=0; pc/alu regs may load but are don't-care.
  - stall (no flush): all regs hold.
  - else: inst_mem<=inst_ex, valid_wb<=inst_ex_valid, pc/alu regs<=pc_ex/alu_ex.
- Latency: inst_ex at edge N appears on inst_mem/wb_data/rf_we after edge N. wb_data is combinational from registered state and dmem_dout.
- wb_data select (opcode=inst_mem[6:0]):
  - LOAD (0000011): formatted dmem_dout, using funct3=inst_mem[14:12] and off=alu_reg[1:0].
  - JAL (1101111) / JALR (1100111): pc_reg+4, modulo 2^32.
  - otherwise: alu_reg.
- Load formatting:
  - LB(000)/LBU(100): byte dmem_dout[8*off+7:8*off], sign/zero extend.
  - LH(001)/LHU(101): halfword chosen by off[1] only (off[0] ignored), sign/zero extend.
  - LW(010) and any other funct3: raw dmem_dout.
- rf_we = valid_wb && rf_wa!=0 && opcode not STORE(0100011), BRANCH(1100011), CSR(1110011). rf_we is always 0 for a bubble even if the instruction field decodes as a write.
- cycle_cnt: +1 every edge out of reset, including stalls; wraps at 2^CNT_WIDTH.
- instret_cnt: +1 on each edge where the register loads with inst_ex_valid=1 and no stall/flush; wraps.
- cnt_clr on an edge sets both counters to 0. Clear wins over a simultaneous increment, so the value is 0, not 1.
- Reset asserted mid-stall or mid-flush: reset values apply immediately, overriding all.

Test Plan:
- Reset then 3 idle edges with inst_ex_valid=0 -> inst_mem=0x00000013, rf_we=0, cycle_cnt=3, instret_cnt=0.
- inst_ex=addi x5,x0,7 (0x00700293), alu_ex=7, valid -> after 1 edge: rf_we=1, rf_wa=5, wb_data=7, instret_cnt=1.
- LB x6 with alu_ex=0x1003, dmem_dout=0x80FF_0102 -> wb_data=0xFFFF_FF80. LHU with alu_ex=0x1002 and the same data -> wb_data=0x0000_80FF.
- JAL x1 with pc_ex=0xFFFF_FFFC -> wb_data=0x0000_0000, rf_we=1, rf_wa=1.
- addi in flight with stall=1 for 2 edges -> inst_mem/wb_data held, instret_cnt unchanged, cycle_cnt+2. Then stall=1 and flush=1 together -> inst_mem=NOP, valid_wb=0, rf_we=0.
- cnt_clr=1 on the same edge as a valid load -> both counters 0. SW to x0-field instruction (0x00502023) -> rf_we=0.
